// File: rtl/id_pkg.sv
// Shared decode constants and the decoded-instruction record for the ID stage.
// MIPS field widths are fixed by the ISA, so the record uses fixed widths.
package id_pkg;

  localparam logic RstEnable    = 1'b0;
  localparam logic RstDisable   = 1'b1;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadDisable  = 1'b0;
  localparam logic InstValid    = 1'b0;
  localparam logic InstInvalid  = 1'b1;
  localparam logic [31:0] ZeroWord = 32'h0;

  // primary opcodes
  localparam logic [5:0] EXE_SPECIAL = 6'b000000;
  localparam logic [5:0] EXE_ANDI    = 6'b001100;
  localparam logic [5:0] EXE_ORI     = 6'b001101;
  localparam logic [5:0] EXE_XORI    = 6'b001110;
  localparam logic [5:0] EXE_LUI     = 6'b001111;

  // SPECIAL funct codes
  localparam logic [5:0] EXE_AND = 6'b100100;
  localparam logic [5:0] EXE_OR  = 6'b100101;
  localparam logic [5:0] EXE_XOR = 6'b100110;
  localparam logic [5:0] EXE_NOR = 6'b100111;
  localparam logic [5:0] EXE_SLL = 6'b000000;
  localparam logic [5:0] EXE_SRL = 6'b000010;
  localparam logic [5:0] EXE_SRA = 6'b000011;

  localparam logic [7:0] EXE_NOP_OP = 8'b00000000;
  localparam logic [7:0] EXE_AND_OP = 8'b00100100;
  localparam logic [7:0] EXE_OR_OP  = 8'b00100101;
  localparam logic [7:0] EXE_XOR_OP = 8'b00100110;
  localparam logic [7:0] EXE_NOR_OP = 8'b00100111;
  localparam logic [7:0] EXE_SLL_OP = 8'b01111100;
  localparam logic [7:0] EXE_SRL_OP = 8'b00000010;
  localparam logic [7:0] EXE_SRA_OP = 8'b00000011;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

  typedef struct packed {
    logic        reg1_read;
    logic        reg2_read;
    logic [4:0]  reg1_addr;
    logic [4:0]  reg2_addr;
    logic [31:0] imm;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [4:0]  wd;
    logic        wreg;
    logic        inst_invalid;
  } id_dec_t;

endpackage

// File: rtl/id_stage_pipe_if.sv
// ID -> EX bundle channel: registered decoded bundle with valid/ready.
interface id_stage_pipe_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 8,
  parameter int ALUSEL_W   = 3
);
  logic                  out_valid;
  logic                  out_ready;
  logic [ALUOP_W-1:0]    aluop_o;
  logic [ALUSEL_W-1:0]   alusel_o;
  logic [DATA_W-1:0]     reg1_o;
  logic [DATA_W-1:0]     reg2_o;
  logic [REG_ADDR_W-1:0] wd_o;
  logic                  wreg_o;
  logic [31:0]           pc_o;
  logic                  inst_invalid_o;

  modport master (
    output out_valid, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, pc_o, inst_invalid_o,
    input  out_ready
  );

  modport slave (
    input  out_valid, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, pc_o, inst_invalid_o,
    output out_ready
  );
endinterface

// File: rtl/id_decode.sv
// Pure combinational MIPS decoder: instruction word -> read ports, immediate, ALU control.
module id_decode
  import id_pkg::*;
(
  input  logic [31:0] inst,
  output id_dec_t     dec
);

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm16;

  assign op    = inst[31:26];
  assign rs    = inst[25:21];
  assign rt    = inst[20:16];
  assign rd    = inst[15:11];
  assign sa    = inst[10:6];
  assign funct = inst[5:0];
  assign imm16 = inst[15:0];

  always_comb begin
    dec              = '0;
    dec.reg1_addr    = rs;
    dec.reg2_addr    = rt;
    dec.aluop        = EXE_NOP_OP;
    dec.alusel       = EXE_RES_NOP;
    dec.inst_invalid = InstInvalid;
    case (op)
      EXE_SPECIAL: begin
        case (funct)
          EXE_AND, EXE_OR, EXE_XOR, EXE_NOR: begin
            dec.reg1_read    = ReadEnable;
            dec.reg2_read    = ReadEnable;
            dec.wd           = rd;
            dec.wreg         = WriteEnable;
            dec.alusel       = EXE_RES_LOGIC;
            dec.inst_invalid = InstValid;
            case (funct)
              EXE_AND: dec.aluop = EXE_AND_OP;
              EXE_OR:  dec.aluop = EXE_OR_OP;
              EXE_XOR: dec.aluop = EXE_XOR_OP;
              default: dec.aluop = EXE_NOR_OP;
            endcase
          end
          // shift amount rides on port 1 as an immediate
          EXE_SLL, EXE_SRL, EXE_SRA: begin
            dec.reg2_read    = ReadEnable;
            dec.imm          = {27'b0, sa};
            dec.wd           = rd;
            dec.wreg         = WriteEnable;
            dec.alusel       = EXE_RES_SHIFT;
            dec.inst_invalid = InstValid;
            case (funct)
              EXE_SLL: dec.aluop = EXE_SLL_OP;
              EXE_SRL: dec.aluop = EXE_SRL_OP;
              default: dec.aluop = EXE_SRA_OP;
            endcase
          end
          default: ;
        endcase
      end
      EXE_ANDI, EXE_ORI, EXE_XORI: begin
        dec.reg1_read    = ReadEnable;
        dec.imm          = {16'b0, imm16};
        dec.wd           = rt;
        dec.wreg         = WriteEnable;
        dec.alusel       = EXE_RES_LOGIC;
        dec.inst_invalid = InstValid;
        case (op)
          EXE_ANDI: dec.aluop = EXE_AND_OP;
          EXE_ORI:  dec.aluop = EXE_OR_OP;
          default:  dec.aluop = EXE_XOR_OP;
        endcase
      end
      EXE_LUI: begin
        dec.imm          = {imm16, 16'b0};
        dec.wd           = rt;
        dec.wreg         = WriteEnable;
        dec.aluop        = EXE_OR_OP;
        dec.alusel       = EXE_RES_LOGIC;
        dec.inst_invalid = InstValid;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Registered ID stage: decode, operand forwarding, load-use stall and an
// ID/EX output register behind a valid/ready handshake with flush.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 8,
  parameter int ALUSEL_W   = 3,
  parameter int FWD_EN     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           pc_i,
  input  logic [31:0]           inst_i,
  output logic                  reg1_read_o,
  output logic                  reg2_read_o,
  output logic [REG_ADDR_W-1:0] reg1_addr_o,
  output logic [REG_ADDR_W-1:0] reg2_addr_o,
  input  logic [DATA_W-1:0]     reg1_data_i,
  input  logic [DATA_W-1:0]     reg2_data_i,
  input  logic                  ex_wreg_i,
  input  logic [REG_ADDR_W-1:0] ex_wd_i,
  input  logic [DATA_W-1:0]     ex_wdata_i,
  input  logic                  ex_is_load_i,
  input  logic                  mem_wreg_i,
  input  logic [REG_ADDR_W-1:0] mem_wd_i,
  input  logic [DATA_W-1:0]     mem_wdata_i,
  input  logic                  flush_i,
  id_stage_pipe_if.master       ex_bus
);

  id_dec_t dec;

  id_decode u_dec (
    .inst (inst_i),
    .dec  (dec)
  );

  logic [1:0]                   rd_en;
  logic [1:0][REG_ADDR_W-1:0]   rd_addr;
  logic [1:0][DATA_W-1:0]       rf_data;
  logic [1:0][DATA_W-1:0]       opnd;
  logic [1:0]                   haz;
  logic [DATA_W-1:0]            imm_ext;
  logic                         accept;

  assign rd_en   = {dec.reg2_read, dec.reg1_read};
  assign rd_addr = {REG_ADDR_W'(dec.reg2_addr), REG_ADDR_W'(dec.reg1_addr)};
  assign rf_data = {reg2_data_i, reg1_data_i};
  assign imm_ext = DATA_W'(dec.imm);

  assign reg1_read_o = rd_en[0];
  assign reg2_read_o = rd_en[1];
  assign reg1_addr_o = rd_addr[0];
  assign reg2_addr_o = rd_addr[1];

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic              ex_hit, mem_hit, live;
    logic [DATA_W-1:0] val;
    logic              stall;

    assign live    = rd_en[p] && (rd_addr[p] != '0);
    assign ex_hit  = ex_wreg_i && (ex_wd_i == rd_addr[p]);
    assign mem_hit = mem_wreg_i && (mem_wd_i == rd_addr[p]);

    always_comb begin
      val   = imm_ext;
      stall = 1'b0;
      if (!rd_en[p])                        val = imm_ext;
      else if (rd_addr[p] == '0)            val = '0;
      else if ((FWD_EN != 0) && ex_hit)     val = ex_wdata_i;
      else if ((FWD_EN != 0) && mem_hit)    val = mem_wdata_i;
      else                                  val = rf_data[p];
      // without forwarding every in-flight RAW must wait for write-back
      if (live)
        stall = (FWD_EN != 0) ? (ex_hit && ex_is_load_i) : (ex_hit || mem_hit);
    end

    assign opnd[p] = val;
    assign haz[p]  = stall;
  end

  assign in_ready = (!ex_bus.out_valid || ex_bus.out_ready) && !(|haz);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      ex_bus.out_valid      <= 1'b0;
      ex_bus.aluop_o        <= ALUOP_W'(EXE_NOP_OP);
      ex_bus.alusel_o       <= ALUSEL_W'(EXE_RES_NOP);
      ex_bus.reg1_o         <= '0;
      ex_bus.reg2_o         <= '0;
      ex_bus.wd_o           <= '0;
      ex_bus.wreg_o         <= WriteDisable;
      ex_bus.pc_o           <= ZeroWord;
      ex_bus.inst_invalid_o <= 1'b0;
    end else begin
      if (flush_i)                ex_bus.out_valid <= 1'b0;
      else if (accept)            ex_bus.out_valid <= 1'b1;
      else if (ex_bus.out_ready)  ex_bus.out_valid <= 1'b0;
      // flush wins over a coincident accept: the killed bundle never loads
      if (accept && !flush_i) begin
        ex_bus.aluop_o        <= ALUOP_W'(dec.aluop);
        ex_bus.alusel_o       <= ALUSEL_W'(dec.alusel);
        ex_bus.reg1_o         <= opnd[0];
        ex_bus.reg2_o         <= opnd[1];
        ex_bus.wd_o           <= REG_ADDR_W'(dec.wd);
        ex_bus.wreg_o         <= dec.wreg;
        ex_bus.pc_o           <= pc_i;
        ex_bus.inst_invalid_o <= dec.inst_invalid;
      end
    end
  end

endmodule
